// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM encoding and the big-endian byte-shift helper.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ADDR_STEP  = 32'd4;

    // Append a byte at the LSB end; the first byte shifted in ends up as the MSB.
    function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into a big-endian 32-bit word.
// o_last_byte marks that the next shifted byte completes the word.
module word_assembler
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last_byte
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;

    // Shift register and byte index; clear wins over shift.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
        end else if (i_shift) begin
            r_word     <= shift_in(r_word, i_byte);
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    assign o_word      = r_word;
    assign o_last_byte = (r_byte_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian words,
// holding the CPU until the whole program has been written.
module imem_loader
    import mips_pkg::*;
#(
    parameter int          MEM_SIZE  = 256,
    parameter int          MAX_WORDS = MEM_SIZE / 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_hold,
    output logic        o_load_done,
    output logic        o_load_error
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic [7:0]  r_count_hi;
    logic [15:0] r_remaining;
    logic [31:0] r_addr;

    logic        w_xfer;
    logic [15:0] w_count;
    logic        w_asm_clear;
    logic        w_asm_shift;
    logic        w_last_byte;
    logic [31:0] w_word;

    assign w_xfer      = i_in_valid & o_in_ready;
    assign w_count     = {r_count_hi, i_in_data};
    assign w_asm_shift = (r_state == DATA) && w_xfer;
    assign w_asm_clear = ((r_state == HDR_LO) && w_xfer) || (r_state == WRITE);

    word_assembler u_word_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_asm_clear),
        .i_shift     (w_asm_shift),
        .i_byte      (i_in_data),
        .o_word      (w_word),
        .o_last_byte (w_last_byte)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE and ERROR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = HDR_HI;
                else         w_next_state = IDLE;
            end
            HDR_HI: begin
                if (w_xfer) w_next_state = HDR_LO;
                else        w_next_state = HDR_HI;
            end
            HDR_LO: begin
                if (!w_xfer)                   w_next_state = HDR_LO;
                else if (w_count == 16'd0)     w_next_state = DONE;
                else if (w_count > MAX_COUNT)  w_next_state = ERROR;
                else                           w_next_state = DATA;
            end
            DATA: begin
                if (w_xfer && w_last_byte) w_next_state = WRITE;
                else                       w_next_state = DATA;
            end
            WRITE: begin
                if (r_remaining == 16'd1) w_next_state = DONE;
                else                      w_next_state = DATA;
            end
            DONE:    w_next_state = IDLE;
            ERROR: begin
                if (i_start) w_next_state = HDR_HI;
                else         w_next_state = ERROR;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Length header capture, words-remaining counter and write address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count_hi  <= 8'd0;
            r_remaining <= 16'd0;
            r_addr      <= BASE_ADDR;
        end else begin
            case (r_state)
                HDR_HI: begin
                    if (w_xfer) r_count_hi <= i_in_data;
                end
                HDR_LO: begin
                    if (w_xfer) begin
                        r_remaining <= w_count;
                        r_addr      <= BASE_ADDR;
                    end
                end
                WRITE: begin
                    r_addr      <= r_addr + ADDR_STEP;
                    r_remaining <= r_remaining - 16'd1;
                end
                default: begin
                    r_remaining <= r_remaining;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe;
    // the write word includes the byte accepted on the edge that enters WRITE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_in_ready   <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= BASE_ADDR;
            o_mem_wdata  <= 32'd0;
            o_cpu_hold   <= 1'b0;
            o_load_done  <= 1'b0;
            o_load_error <= 1'b0;
        end else begin
            o_in_ready   <= (w_next_state == HDR_HI) || (w_next_state == HDR_LO) ||
                            (w_next_state == DATA);
            o_mem_we     <= (w_next_state == WRITE);
            o_cpu_hold   <= (w_next_state != IDLE);
            o_load_done  <= (w_next_state == DONE);
            o_load_error <= (w_next_state == ERROR);
            if (w_next_state == WRITE) begin
                o_mem_addr  <= r_addr;
                o_mem_wdata <= shift_in(w_word, i_in_data);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a stream-level model predicts the
// memory writes and done pulses, and a negedge monitor checks what the DUT issues.
module tb_imem_loader;

    localparam int          MAX_WORDS = 64;
    localparam logic [31:0] BASE      = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_seen = 0;
    int exp_done = 0;
    int hold_cnt = 0;
    int d0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  stream[$];
    logic [31:0] mon_a, mon_d;

    imem_loader #(.MEM_SIZE(256), .MAX_WORDS(64), .BASE_ADDR(32'h0)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_cpu_hold   (cpu_hold),
        .o_load_done  (load_done),
        .o_load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_addr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                if (mem_addr !== mon_a || mem_wdata !== mon_d) begin
                    failures++;
                    $display("FAIL write: got addr %h data %h, required addr %h data %h",
                             mem_addr, mem_wdata, mon_a, mon_d);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL we_with_ready: got in_ready %b during write, required 0", in_ready);
            end
        end
        if (load_done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (cpu_hold === 1'b1) hold_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: length header, then count big-endian words at BASE+4k.
    task automatic model_load();
        int cnt;
        cnt = int'(stream[0]) * 256 + int'(stream[1]);
        if (cnt == 0) begin
            exp_done++;
        end else if (cnt <= MAX_WORDS) begin
            for (int k = 0; k < cnt; k++) begin
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back({stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
            end
            exp_done++;
        end
    endtask

    task automatic build_stream(input int cnt);
        logic [15:0] c;
        c = 16'(cnt);
        stream.delete();
        stream.push_back(c[15:8]);
        stream.push_back(c[7:0]);
        for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            in_valid = 1'b0;
            repeat (n) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got in_ready 0 for 40 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gaps, input int start_at, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (i == start_at) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(posedge clk); #1;
                start    = 1'b0;
            end
            send_byte(stream[i], gaps);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (cpu_hold && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (cpu_hold) begin
            failures++;
            $display("FAIL idle_timeout: got cpu_hold 1 after 1000 cycles, required 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic run_load(input bit gaps, input int start_at);
        model_load();
        start_load();
        send_stream(gaps, start_at, stream.size());
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   mem_addr,        BASE);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
        chk({tag, "_load_done"},  32'(load_done),  32'd0);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word reference load, no gaps: latency and hold window are exact.
        stream = '{8'h00, 8'h02, 8'h00, 8'h21, 8'h40, 8'h20, 8'h00, 8'h01, 8'h48, 8'h20};
        d0 = done_seen; hold_cnt = 0;
        run_load(1'b0, -1);
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd12);
        chk("t1_hold_cycles", 32'(hold_cnt), 32'd13);
        chk("t1_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("t1_writes_left", 32'(exp_addr.size()), 32'd0);

        // Same stream with random valid gaps.
        d0 = done_seen;
        run_load(1'b1, -1);
        chk("t2_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("t2_writes_left", 32'(exp_addr.size()), 32'd0);

        // Zero length: done one cycle after the second header byte, then idle.
        stream = '{8'h00, 8'h00};
        d0 = done_seen;
        run_load(1'b0, -1);
        chk("t3_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        chk("t3_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("t3_idle_ready", 32'(in_ready), 32'd0);
        chk("t3_idle_hold", 32'(cpu_hold), 32'd0);

        // Oversize header (65 words) parks in the error state.
        stream = '{8'h00, 8'h41};
        d0 = done_seen;
        model_load();
        start_load();
        send_stream(1'b0, -1, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_error", 32'(load_error), 32'd1);
        chk("t4_ready", 32'(in_ready), 32'd0);
        chk("t4_hold", 32'(cpu_hold), 32'd1);
        chk("t4_no_done", 32'(done_seen - d0), 32'd0);
        @(posedge clk); #1;
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_load();
        start_load();
        @(negedge clk);
        chk("t4_error_cleared", 32'(load_error), 32'd0);
        @(posedge clk); #1;
        send_stream(1'b0, -1, stream.size());
        wait_idle();
        chk("t4_writes_left", 32'(exp_addr.size()), 32'd0);

        // Reset after the second data byte of word 1 of a 3-word load.
        build_stream(3);
        start_load();
        send_stream(1'b0, -1, 4);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t5");
        @(posedge clk); #1;
        reset = 1'b0;
        build_stream(2);
        run_load(1'b1, -1);
        chk("t5_writes_left", 32'(exp_addr.size()), 32'd0);

        // Start pulse in the middle of DATA must be ignored.
        build_stream(2);
        run_load(1'b0, 4);
        chk("t6_writes_left", 32'(exp_addr.size()), 32'd0);

        // Random lengths with gaps, then the largest legal program.
        for (int i = 0; i < 5; i++) begin
            build_stream(int'($urandom_range(1, 6)));
            run_load(1'b1, -1);
        end
        build_stream(MAX_WORDS);
        run_load(1'b0, -1);

        chk("final_done_count", 32'(done_seen), 32'(exp_done));
        chk("final_writes_left", 32'(exp_addr.size()), 32'd0);
        chk("final_no_error", 32'(load_error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
